// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and constants for the two-requester Gray conversion arbiter.
package gray_conv_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    REQ_ID0 = 1'b0,
    REQ_ID1 = 1'b1
  } req_id_e;

  // Requester 1 marked as last served so requester 0 wins the first contest.
  localparam req_id_e LAST_GRANT_RST = REQ_ID1;

endpackage

// File: rtl/gray_conv_arbiter_bin2gray_core.sv
// Purpose: binary-to-Gray encoder, gray = bin ^ (bin >> 1).
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no flow control of its own.
module bin2gray_core #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Purpose: round-robin share of one Gray encoder between two requesters, ID-tagged output.
// Latency: 1 cycle from grant to out_valid; 1 conversion per cycle sustained.
// Backpressure: no grant while the output holds data and out_ready is low.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] conv_count
);

  req_id_e          last_grant;
  req_id_e          sel_id;
  req_id_e          out_id_r;
  logic             slot_free;
  logic [WIDTH-1:0] bin_sel;
  logic [WIDTH-1:0] gray_sel;

  // The slot frees up in the same cycle the consumer drains it.
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && slot_free) begin
      if (req0 && req1) begin
        if (last_grant == REQ_ID1) gnt0 = 1'b1;
        else                       gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign sel_id  = gnt1 ? REQ_ID1 : REQ_ID0;
  assign bin_sel = gnt1 ? bin1 : bin0;

  bin2gray_core #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (bin_sel),
    .gray (gray_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_gray   <= '0;
      out_id_r   <= REQ_ID0;
      last_grant <= LAST_GRANT_RST;
      conv_count <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        out_valid  <= 1'b1;
        out_gray   <= gray_sel;
        out_id_r   <= sel_id;
        last_grant <= sel_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        conv_count <= conv_count + CNT_W'(1);
      end
    end
  end

  assign out_id = out_id_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed-vector bench: stimulus pushes hand-computed results, a monitor pops on each output transfer.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  bin0, bin1;
  logic        gnt0, gnt1;
  logic        out_valid;
  logic [2:0]  out_gray;
  logic        out_id;
  logic        out_ready;
  logic [15:0] conv_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb_q [$];
  logic [2:0] gtab [0:7];

  gray_conv_arbiter #(.WIDTH(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .bin0       (bin0),
    .req1       (req1),
    .bin1       (bin1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .out_valid  (out_valid),
    .out_gray   (out_gray),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got id=%0d gray=%b expected nothing", out_id, out_gray);
      end else begin
        chk("out_id_gray", 32'({out_id, out_gray}), 32'(sb_q.pop_front()));
      end
    end
  end

  // One cycle of stimulus; gnt and out_valid checked mid-cycle, expected output queued on grant.
  task automatic step(input logic r0, input logic [2:0] b0, input logic r1, input logic [2:0] b1,
                      input logic rdy, input logic [1:0] eg, input logic [2:0] egray, input logic ev);
    req0 = r0; bin0 = b0; req1 = r1; bin1 = b1; out_ready = rdy;
    @(negedge clk);
    chk("gnt", 32'({gnt1, gnt0}), 32'(eg));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (eg == 2'b01) sb_q.push_back({1'b0, egray});
    if (eg == 2'b10) sb_q.push_back({1'b1, egray});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; bin0 = 3'b000; bin1 = 3'b000; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gray", 32'(out_gray), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_conv_count", 32'(conv_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from requester 0
    step(1, 3'b101, 0, 3'b000, 1, 2'b01, 3'b111, 0);
    step(0, 3'b000, 0, 3'b000, 1, 2'b00, 3'b000, 1);

    // Both requesting: alternation starting from requester 0 after reset
    do_reset();
    step(1, 3'b110, 1, 3'b011, 1, 2'b01, 3'b101, 0);
    step(1, 3'b110, 1, 3'b011, 1, 2'b10, 3'b010, 1);
    step(1, 3'b110, 1, 3'b011, 1, 2'b01, 3'b101, 1);
    step(1, 3'b110, 1, 3'b011, 1, 2'b10, 3'b010, 1);

    // Backpressure with requester 1 waiting
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b000, 1, 3'b100, 0, 2'b00, 3'b000, 1);
      chk("frozen_out", 32'({out_id, out_gray}), 32'({1'b1, 3'b010}));
    end
    step(0, 3'b000, 1, 3'b100, 1, 2'b10, 3'b110, 1);
    step(0, 3'b000, 0, 3'b000, 1, 2'b00, 3'b000, 1);
    chk("count_after_bp", 32'(conv_count), 32'd5);

    // Full sweep of requester 0 at one per cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 3'(i), 0, 3'b000, 1, 2'b01, gtab[i], i != 0);
    end
    step(0, 3'b000, 0, 3'b000, 1, 2'b00, 3'b000, 1);
    chk("sweep_count", 32'(conv_count), 32'd8);

    // Reset with a pending output and both requesters active
    step(1, 3'b110, 1, 3'b011, 1, 2'b10, 3'b010, 0);
    rst = 1'b1; out_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("mid_rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(conv_count), 32'd0);
    rst = 1'b0;
    step(1, 3'b110, 1, 3'b011, 1, 2'b01, 3'b101, 0);
    step(0, 3'b000, 0, 3'b000, 1, 2'b00, 3'b000, 1);

    // Withdrawn request while stalled leaves arbitration state alone
    step(1, 3'b001, 0, 3'b000, 1, 2'b01, 3'b001, 0);
    step(0, 3'b000, 1, 3'b111, 0, 2'b00, 3'b000, 1);
    step(0, 3'b000, 0, 3'b000, 0, 2'b00, 3'b000, 1);
    step(1, 3'b001, 1, 3'b111, 1, 2'b10, 3'b100, 1);
    step(0, 3'b000, 0, 3'b000, 1, 2'b00, 3'b000, 1);
    step(0, 3'b000, 0, 3'b000, 1, 2'b00, 3'b000, 0);
    chk("final_count", 32'(conv_count), 32'd3);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one binary-to-Gray conversion datapath between two requesters.
- Arbitration is round-robin. Each requester has a valid/grant handshake.
- The result goes into one registered output stage with valid/ready backpressure, tagged with the requester ID.
- Sits between producer blocks (counters, pointer logic) and consumers that need Gray-coded values.

Parameters:
- WIDTH, 3, bit width of binary input and Gray output.
- CNT_W, 16, width of the completed-conversion counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 has a valid binary value
- bin0  input  WIDTH  requester 0 binary value; held stable while req0=1 and gnt0=0
- req1  input  1  requester 1 has a valid binary value
- bin1  input  WIDTH  requester 1 binary value; same hold rule
- gnt0  output  1  combinational; transfer from requester 0 this cycle
- gnt1  output  1  combinational; transfer from requester 1 this cycle
- out_valid  output  1  registered; out_gray/out_id are valid
- out_gray  output  WIDTH  registered Gray code of the granted value
- out_id  output  1  registered; 0 or 1, the requester that produced out_gray
- out_ready  input  1  consumer accepts the output this cycle
- conv_count  output  CNT_W  registered count of completed output transfers

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Values after reset: out_valid=0, out_gray=0, out_id=0, conv_count=0, last_grant=1.
  - With last_grant=1, requester 0 wins the first contest.
  - gnt0=gnt1=0 while rst=1.
- Conversion: gray = bin ^ (bin >> 1), bitwise over WIDTH. Combinational on the selected input, captured in the output register.
- Output slot free: free = !out_valid | out_ready. No grant is issued unless free=1.
- Grant rules, evaluated when free=1:
  - req0 only -> gnt0=1.
  - req1 only -> gnt1=1.
  - Both requests -> grant the requester != last_grant.
  - At most one gnt high per cycle. A gnt is never high without its req.
- On a grant at edge N:
  - out_valid=1, out_gray=Gray(bin_sel) and out_id=sel at edge N+1.
  - last_grant=sel.
  - Latency is 1 cycle from grant to out_valid.
- Drain: out_valid & out_ready at an edge with no new grant -> out_valid=0. out_gray and out_id hold their last values.
- Simultaneous drain and grant: the output register reloads with the new value. out_valid stays 1, giving throughput of 1 conversion per cycle.
- Backpressure: out_valid=1 & out_ready=0 -> out_gray and out_id stable, gnt0=gnt1=0, last_grant unchanged.
- conv_count increments by 1 on every edge with out_valid & out_ready. Wraps from all-ones to 0.
- Reset mid-operation:
  - A pending output is discarded (out_valid=0 next edge).
  - Requesters that were not yet granted must keep req asserted. They are served after reset deasserts, with requester 0 first.
- A req that drops without a grant is legal (request withdrawn). No state is affected.

Decomposition:
- Shared package holds:
  - the default WIDTH constant;
  - an ID type (requester 0 / requester 1);
  - the reset value of last_grant.
- One natural sub-module: bin2gray_core, a purely combinational, WIDTH-parameterised binary-to-Gray encoder. It is instantiated once on the muxed input.
- Arbiter, output register and counter stay in the top module.

Test Plan:
- Reset, then req0=1, bin0=3'b101 -> gnt0 same cycle; next cycle out_valid=1, out_gray=3'b111, out_id=0.
- req0 and req1 both held, bin0=3'b110, bin1=3'b011, out_ready=1:
  - first grants alternate 0,1,0,1;
  - out_gray alternates 3'b101, 3'b010;
  - out_valid stays 1 every cycle.
- out_ready=0 for 3 cycles with out_valid=1 and req1=1 (bin1=3'b100):
  - out_* frozen, gnt1=0 throughout;
  - on out_ready=1, gnt1 pulses; next cycle out_gray=3'b110, out_id=1.
- Sweep bin0 over 3'b000..3'b111 with out_ready=1 -> out_gray = 000,001,011,010,110,111,101,100; conv_count = 8.
- Assert rst while out_valid=1 and both reqs high:
  - next edge out_valid=0, conv_count=0;
  - after release, the first grant goes to requester 0.
- Withdraw req1 before grant while req0 is idle -> no gnt, out_valid unchanged, last_grant unchanged.
